// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// A 2-flop synchroniser feeds the FSM. The start bit is validated at its midpoint and every
// data/stop bit is sampled at mid-bit. A good byte is presented with a one-cycle o_Rx_DV pulse.
// A low stop bit gives a one-cycle o_Frame_Err pulse.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the data bits.
// PARITY_ODD selects the parity sense: 0 = even, 1 = odd.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err
);

  localparam logic [7:0] HalfCnt = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] BitTerm = 8'(CLKS_PER_BIT - 1);

  // Reject parameter values the 8-bit counter or the parity select cannot represent.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 255) begin : g_bad_clks
    $error("uart_rx: CLKS_PER_BIT must be in 4..255");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    StWaitIdle = 3'd0,
    StIdle     = 3'd1,
    StStart    = 3'd2,
    StData     = 3'd3,
    StParity   = 3'd4,
    StStop     = 3'd5,
    StCleanup  = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] byte_q, byte_d;
  logic       dv_q, dv_d;
  logic       fe_q, fe_d;
  logic       active_q, active_d;
`ifdef UART_RX_PARITY_EN
  localparam logic ParOdd = PARITY_ODD[0];
  logic       pe_q, pe_d;
  logic       par_err_q, par_err_d;
`endif

  // Synchroniser and state registers; reset also aborts any frame in progress.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
      state_q   <= StWaitIdle;
      cnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      data_q    <= 8'h00;
      byte_q    <= 8'h00;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      active_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q      <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      active_q  <= active_d;
`ifdef UART_RX_PARITY_EN
      pe_q      <= pe_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  // Next-state logic: bit timing, data assembly and the registered result pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    idx_d     = idx_q;
    data_d    = data_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    active_d  = active_q;
`ifdef UART_RX_PARITY_EN
    pe_d      = 1'b0;
    par_err_d = par_err_q;
`endif
    case (state_q)
      // Hold off until the line is seen high so a frame or break in progress is ignored.
      StWaitIdle: begin
        cnt_d    = 8'd0;
        active_d = 1'b0;
        if (rx_s_q) state_d = StIdle;
      end
      StIdle: begin
        cnt_d    = 8'd0;
        active_d = 1'b0;
        if (!rx_s_q) begin
          state_d  = StStart;
          active_d = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = 8'd0;
          if (!rx_s_q) begin
            state_d = StData;
            idx_d   = 3'd0;
          end else begin
            // Start bit gone by mid-bit: a glitch, not a frame.
            state_d  = StIdle;
            active_d = 1'b0;
          end
        end
      end
      StData: begin
        if (cnt_q == BitTerm) begin
          cnt_d         = 8'd0;
          data_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitTerm) begin
          cnt_d     = 8'd0;
          par_err_d = rx_s_q != ((^data_q) ^ ParOdd);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitTerm) begin
          cnt_d = 8'd0;
          if (!rx_s_q) begin
            // Framing error wins over parity; the last good byte is kept.
            fe_d     = 1'b1;
            state_d  = StWaitIdle;
            active_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            pe_d    = 1'b1;
            state_d = StCleanup;
`endif
          end else begin
            byte_d  = data_q;
            dv_d    = 1'b1;
            state_d = StCleanup;
          end
        end
      end
      // Leaves IDLE reachable about half a bit before the stop bit ends.
      StCleanup: begin
        cnt_d    = 8'd0;
        active_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        cnt_d    = 8'd0;
        active_d = 1'b0;
        state_d  = StWaitIdle;
      end
    endcase
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Active = active_q;
  assign o_Frame_Err = fe_q;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = pe_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Each frame sent pushes its expected result pulse
// (kind, byte, cycle) and the negedge monitor pops and compares every pulse the DUT produces.
// Define UART_RX_PARITY_EN to build the bench and the DUT with the parity bit.
module tb_uart_rx;

  localparam int unsigned Clks   = 87;
  localparam int unsigned Half   = (Clks - 1) / 2;
  localparam logic        ParOdd = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit          ParEn     = 1'b1;
  localparam int unsigned FrameBits = 11;
`else
  localparam bit          ParEn     = 1'b0;
  localparam int unsigned FrameBits = 10;
`endif
  localparam logic [2:0] KDv = 3'b001;
  localparam logic [2:0] KFe = 3'b010;
  localparam logic [2:0] KPe = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [7:0]  data;
    int unsigned cycle;
  } ev_t;

  logic       i_Clock     = 1'b0;
  logic       i_Reset     = 1'b1;
  logic       i_Rx_Serial = 1'b1;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Frame_Err;
  logic       o_Parity_Err;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  ev_t         sb_q[$];
  logic [7:0]  last_good = 8'h00;
  bit          active_seen = 1'b0;
  ev_t         mon_ev;
  logic [2:0]  mon_kind;

  uart_rx #(
    .CLKS_PER_BIT(Clks),
    .PARITY_ODD  (int'(ParOdd))
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_DV     (o_Rx_DV),
    .o_Rx_Byte   (o_Rx_Byte),
    .o_Rx_Active (o_Rx_Active),
    .o_Frame_Err (o_Frame_Err),
    .o_Parity_Err(o_Parity_Err)
  );

  always #5 i_Clock = ~i_Clock;

  // After posedge k, cyc reads k.
  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every result pulse must match the oldest expectation in kind, byte and cycle.
  always @(negedge i_Clock) begin
    if (o_Rx_Active) active_seen = 1'b1;
    if (o_Rx_DV || o_Frame_Err || o_Parity_Err) begin
      mon_kind = {o_Parity_Err, o_Frame_Err, o_Rx_DV};
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", {29'd0, mon_kind}, 32'd0);
      end else begin
        mon_ev = sb_q.pop_front();
        check_eq("pulse_kind", {29'd0, mon_kind}, {29'd0, mon_ev.kind});
        check_eq("rx_byte", {24'd0, o_Rx_Byte}, {24'd0, mon_ev.data});
        check_eq("pulse_cycle", cyc, mon_ev.cycle);
      end
    end
  end

  // Drives one bit for Clks cycles; optionally pulses reset for one cycle mid-bit.
  task automatic send_bit(input logic b, input bit do_rst);
    i_Rx_Serial = b;
    if (do_rst) begin
      repeat (Clks / 2) @(posedge i_Clock);
      #1 i_Reset = 1'b1;
      @(posedge i_Clock);
      #1 i_Reset = 1'b0;
      repeat (Clks - Clks / 2 - 1) @(posedge i_Clock);
      #1;
    end else begin
      repeat (Clks) @(posedge i_Clock);
      #1;
    end
  endtask

  // Sends one frame from a posedge+1 alignment; rst_bit >= 0 resets during that data bit.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input logic stop,
                            input int rst_bit);
    ev_t         ev;
    int unsigned first;
    logic        par;
    par   = (^data) ^ ParOdd ^ bad_par;
    first = cyc + 1;  // first clock edge that sees the start bit
    if (rst_bit < 0) begin
      ev.cycle = first + 3 + Half + (FrameBits - 1) * Clks;
      if (!stop) begin
        ev.kind = KFe;
        ev.data = last_good;
      end else if (ParEn && bad_par) begin
        ev.kind = KPe;
        ev.data = last_good;
      end else begin
        ev.kind   = KDv;
        ev.data   = data;
        last_good = data;
      end
      sb_q.push_back(ev);
    end
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i], i == rst_bit);
      if (i == rst_bit) begin
        last_good = 8'h00;
        check_eq("active_after_reset", {31'd0, o_Rx_Active}, 32'd0);
        check_eq("byte_after_reset", {24'd0, o_Rx_Byte}, 32'd0);
      end
      if (i == 3 && rst_bit < 0) check_eq("active_mid_frame", {31'd0, o_Rx_Active}, 32'd1);
    end
    if (ParEn) send_bit(par, 1'b0);
    send_bit(stop, 1'b0);
    if (rst_bit < 0) check_eq("active_end_frame", {31'd0, o_Rx_Active}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    i_Rx_Serial = 1'b1;
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "tb_uart_rx timed out");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge i_Clock);
    #1;
    check_eq("reset_dv", {31'd0, o_Rx_DV}, 32'd0);
    check_eq("reset_fe", {31'd0, o_Frame_Err}, 32'd0);
    check_eq("reset_pe", {31'd0, o_Parity_Err}, 32'd0);
    check_eq("reset_active", {31'd0, o_Rx_Active}, 32'd0);
    check_eq("reset_byte", {24'd0, o_Rx_Byte}, 32'd0);
    i_Reset = 1'b0;
    idle_cycles(200);

    // Single frame.
    send_frame(8'h37, 1'b0, 1'b1, -1);
    check_eq("sb_empty_single", sb_q.size(), 32'd0);
    idle_cycles(50);

    // Back-to-back frames.
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    check_eq("sb_empty_b2b", sb_q.size(), 32'd0);
    idle_cycles(50);

    // Short low glitch on an idle line.
    active_seen = 1'b0;
    i_Rx_Serial = 1'b0;
    repeat (20) @(posedge i_Clock);
    #1;
    idle_cycles(100);
    check_eq("glitch_active_seen", {31'd0, active_seen}, 32'd1);
    check_eq("glitch_active_low", {31'd0, o_Rx_Active}, 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    check_eq("sb_empty_glitch", sb_q.size(), 32'd0);
    idle_cycles(50);

    // Framing error then a long break, then a good frame.
    send_frame(8'h81, 1'b0, 1'b0, -1);
    i_Rx_Serial = 1'b0;
    repeat (2000) @(posedge i_Clock);
    #1;
    check_eq("break_active_low", {31'd0, o_Rx_Active}, 32'd0);
    check_eq("break_byte_held", {24'd0, o_Rx_Byte}, 32'hFF);
    check_eq("sb_empty_break", sb_q.size(), 32'd0);
    idle_cycles(3 * Clks);
    send_frame(8'h42, 1'b0, 1'b1, -1);
    check_eq("sb_empty_after_break", sb_q.size(), 32'd0);
    idle_cycles(50);

    // Reset during data bit 4, line keeps sending the frame.
    send_frame(8'hC3, 1'b0, 1'b1, 4);
    idle_cycles(3 * Clks);
    check_eq("sb_empty_reset", sb_q.size(), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    check_eq("sb_empty_after_reset", sb_q.size(), 32'd0);
    idle_cycles(50);

`ifdef UART_RX_PARITY_EN
    // Parity: good parity bit, then a bad one.
    send_frame(8'h07, 1'b0, 1'b1, -1);
    idle_cycles(50);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    check_eq("sb_empty_parity", sb_q.size(), 32'd0);
    idle_cycles(50);
`endif

    idle_cycles(20);
    check_eq("sb_empty_final", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
